// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Multi-entry register storage for the LITE-16 datapath. One synchronous
// write port and two independently enabled, registered read ports. A write
// and a read of the same address on the same edge return the new data
// (write-to-read bypass), per port.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined     -> entry 0 reads as zero, writes to it are dropped and it
//                  never bypasses.
//   not defined -> entry 0 is an ordinary register.
//
// Parameters:
//   WIDTH   data width of each entry
//   DEPTH   number of entries (power of two, >= 2)
//   ADDR_W  derived address width
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears entries and read data)
//   we       write enable
//   waddr    write address
//   wdata    write data
//   re_a     read enable, port A
//   raddr_a  read address, port A
//   rdata_a  registered read data, port A
//   re_b     read enable, port B
//   raddr_b  read address, port B
//   rdata_b  registered read data, port B
// ---------------------------------------------------------------------------
module register_file #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             wr_en;

  // A write to entry 0 is treated as no write at all when entry 0 is the
  // zero register, which also removes it from the bypass compare below.
  always_comb begin
    wr_en = we;
    if (ZERO_REG && (waddr == '0)) begin
      wr_en = 1'b0;
    end

    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end

    rdata_a_d = rdata_a_q;
    if (re_a) begin
      if (wr_en && (raddr_a == waddr)) begin
        rdata_a_d = wdata;
      end else begin
        rdata_a_d = regs_q[raddr_a];
      end
    end

    rdata_b_d = rdata_b_q;
    if (re_b) begin
      if (wr_en && (raddr_b == waddr)) begin
        rdata_b_d = wdata;
      end else begin
        rdata_b_d = regs_q[raddr_b];
      end
    end
  end

  // Entry 0 is tied to a constant when it is the zero register, so no real
  // state is kept for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG && (i == 0)) begin
          regs_q[i] <= '0;
        end else begin
          regs_q[i] <= regs_d[i];
        end
      end
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file (default WIDTH=16, DEPTH=8).
// Directed vector table, hand-written reset / zero-register sequences and a
// randomized phase checked against an array-based reference model.
// Honours REGFILE_ZERO_REG_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;

  int checks;
  int failures;

  register_file #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re_a   (re_a),
    .raddr_a(raddr_a),
    .rdata_a(rdata_a),
    .re_b   (re_b),
    .raddr_b(raddr_b),
    .rdata_b(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  exp_a;
    logic [WIDTH-1:0]  exp_b;
  } vec_t;

  vec_t vecs [10];

  // Reference model: storage as a plain array plus last read results.
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] model_a;
  logic [WIDTH-1:0] model_b;

  // Drive one cycle's inputs on the falling edge.
  task automatic applyStimulus(input logic i_we, input logic [ADDR_W-1:0] i_waddr,
                               input logic [WIDTH-1:0] i_wdata,
                               input logic i_re_a, input logic [ADDR_W-1:0] i_raddr_a,
                               input logic i_re_b, input logic [ADDR_W-1:0] i_raddr_b);
    @(negedge clk);
    we      = i_we;
    waddr   = i_waddr;
    wdata   = i_wdata;
    re_a    = i_re_a;
    raddr_a = i_raddr_a;
    re_b    = i_re_b;
    raddr_b = i_raddr_b;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] modelRead(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && addr == '0) return '0;
    return model_mem[addr];
  endfunction

  // Apply the spec's rules for one edge to the model.
  task automatic modelEdge(input logic i_we, input logic [ADDR_W-1:0] i_waddr,
                           input logic [WIDTH-1:0] i_wdata,
                           input logic i_re_a, input logic [ADDR_W-1:0] i_raddr_a,
                           input logic i_re_b, input logic [ADDR_W-1:0] i_raddr_b);
    logic writes;
    writes = i_we && !(ZERO_REG && i_waddr == '0);
    if (i_re_a) model_a = (writes && i_raddr_a == i_waddr) ? i_wdata : modelRead(i_raddr_a);
    if (i_re_b) model_b = (writes && i_raddr_b == i_waddr) ? i_wdata : modelRead(i_raddr_b);
    if (writes) model_mem[i_waddr] = i_wdata;
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_a = '0;
    model_b = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] zero_exp;
    logic              r_we, r_re_a, r_re_b;
    logic [ADDR_W-1:0] r_waddr, r_raddr_a, r_raddr_b;
    logic [WIDTH-1:0]  r_wdata;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;

    // Directed table, starting from an all-zero file. Entry 0 is never
    // written here, so the expectations hold with or without the macro.
    vecs[0] = '{1'b1, 3'd5, 16'hAABB, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd0, 16'hAABB, 16'h0000};
    vecs[2] = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd5, 1'b1, 3'd5, 16'hAABB, 16'h1234};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 3'd2, 16'hAA00, 1'b1, 3'd2, 1'b1, 3'd2, 16'hAA00, 16'hAA00};
    vecs[5] = '{1'b1, 3'd1, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0, 16'hAA00, 16'hAA00};
    vecs[6] = '{1'b0, 3'd1, 16'hFFFF, 1'b1, 3'd1, 1'b0, 3'd0, 16'h5555, 16'hAA00};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 3'd2, 16'h5555, 16'hAA00};
    vecs[8] = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 1'b1, 3'd6, 16'hFFFF, 16'h0000};
    vecs[9] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd7, 16'h0000, 16'hFFFF};

    #2;
    checkOutput("reset_rdata_a", rdata_a, 16'h0000);
    checkOutput("reset_rdata_b", rdata_b, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                    vecs[i].re_a, vecs[i].raddr_a, vecs[i].re_b, vecs[i].raddr_b);
      stepEdge();
      checkOutput($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
    end

    // Asynchronous reset in mid-cycle, with a write pending when it lands.
    applyStimulus(1'b1, 3'd3, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3);
    stepEdge();
    checkOutput("pre_reset_a", rdata_a, 16'hFFFF);
    checkOutput("pre_reset_b", rdata_b, 16'hFFFF);
    we = 1'b1; waddr = 3'd3; wdata = 16'h1111; re_a = 1'b0; re_b = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_a", rdata_a, 16'h0000);
    checkOutput("async_reset_b", rdata_b, 16'h0000);
    stepEdge();
    // First edge after release performs the presented write and bypassed read.
    applyStimulus(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 1'b0, 3'd0);
    rst_n = 1'b1;
    stepEdge();
    checkOutput("release_edge_a", rdata_a, 16'h4444);
    checkOutput("release_edge_b", rdata_b, 16'h0000);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd4);
    stepEdge();
    checkOutput("reg3_after_reset", rdata_a, 16'h0000);
    checkOutput("reg4_after_release", rdata_b, 16'h4444);

    // Zero register: same-edge bypass and later read of entry 0.
    zero_exp = ZERO_REG ? 16'h0000 : 16'hBEEF;
    applyStimulus(1'b1, 3'd0, 16'hBEEF, 1'b1, 3'd0, 1'b1, 3'd0);
    stepEdge();
    checkOutput("zero_bypass_a", rdata_a, zero_exp);
    checkOutput("zero_bypass_b", rdata_b, zero_exp);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd4);
    stepEdge();
    checkOutput("zero_later_a", rdata_a, zero_exp);
    checkOutput("zero_later_b", rdata_b, 16'h4444);

    // Randomized phase from a fresh reset against the reference model.
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r_we      = 1'($urandom_range(0, 1));
      r_waddr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      r_wdata   = WIDTH'($urandom);
      r_re_a    = ($urandom_range(0, 3) != 0);
      r_raddr_a = ADDR_W'($urandom_range(0, DEPTH - 1));
      r_re_b    = ($urandom_range(0, 3) != 0);
      r_raddr_b = ($urandom_range(0, 3) == 0) ? r_raddr_a : ADDR_W'($urandom_range(0, DEPTH - 1));
      applyStimulus(r_we, r_waddr, r_wdata, r_re_a, r_raddr_a, r_re_b, r_raddr_b);
      modelEdge(r_we, r_waddr, r_wdata, r_re_a, r_raddr_a, r_re_b, r_raddr_b);
      stepEdge();
      checkOutput($sformatf("rand%0d_a", n), rdata_a, model_a);
      checkOutput($sformatf("rand%0d_b", n), rdata_b, model_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
